// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control sequencer for the 8-bit Harvard datapath.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB and drives the
// PC/IR/ALU/register-file/data-memory strobes. The data-memory handshake is
// bounded by MEM_TIMEOUT; expiry halts the sequencer with a sticky fault flag.
// Optional feature macro: CTRL_SINGLE_STEP_EN adds an i_step input and a
// STEP_WAIT state so that exactly one instruction executes per step pulse.
// Strobes are registered from the next-state decode, so they line up with the
// state they belong to; o_pc_load is the one output that is combinational,
// because it follows i_zero_flag during EXEC for JZ.
module cpu_ctrl_fsm #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned TO_W        = 8
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_run,
   input  logic [3:0] i_opcode,
   input  logic       i_zero_flag,
   input  logic       i_dmem_ready,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic       i_step,
`endif
   output logic       o_ir_load,
   output logic       o_pc_inc,
   output logic       o_pc_load,
   output logic       o_alu_en,
   output logic [2:0] o_alu_op,
   output logic       o_rf_we,
   output logic [1:0] o_rf_src,
   output logic       o_dmem_re,
   output logic       o_dmem_we,
   output logic       o_halted,
   output logic       o_fault,
   output logic [2:0] o_state
);

`ifdef CTRL_SINGLE_STEP_EN
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXEC      = 3'd3,
      S_MEM       = 3'd4,
      S_WB        = 3'd5,
      S_HALT      = 3'd6,
      S_STEP_WAIT = 3'd7
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;
`endif

   typedef struct packed {
      logic       ir_load;
      logic       pc_inc;
      logic       alu_en;
      logic [2:0] alu_op;
      logic       rf_we;
      logic [1:0] rf_src;
      logic       dmem_re;
      logic       dmem_we;
      logic       halted;
   } ctrl_t;

   localparam logic [3:0]      OP_LD   = 4'h8;
   localparam logic [3:0]      OP_ST   = 4'h9;
   localparam logic [3:0]      OP_JMP  = 4'hA;
   localparam logic [3:0]      OP_JZ   = 4'hB;
   localparam logic [3:0]      OP_LDI  = 4'hC;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   // Moore strobe decode for a given state and latched opcode.
   function automatic ctrl_t decode_ctrl(input state_t st, input logic [3:0] op);
      ctrl_t      c;
      logic [3:0] alu_idx;
      c       = '0;
      alu_idx = op - 4'd1;
      case (st)
         S_FETCH: begin
            c.ir_load = 1'b1;
            c.pc_inc  = 1'b1;
         end
         S_EXEC: begin
            case (op)
               4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                  c.alu_en = 1'b1;
                  c.alu_op = alu_idx[2:0];
               end
               4'h6: begin
                  c.alu_en = 1'b1;
                  c.alu_op = 3'd5;
               end
               4'h7: begin
                  c.alu_en = 1'b1;
                  c.alu_op = 3'd6;
               end
               default: c.alu_en = 1'b0;
            endcase
         end
         S_MEM: begin
            c.dmem_re = (op == OP_LD);
            c.dmem_we = (op == OP_ST);
         end
         S_WB: begin
            c.rf_we = 1'b1;
            if (op == OP_LD) begin
               c.rf_src = 2'd1;
            end else if (op == OP_LDI) begin
               c.rf_src = 2'd2;
            end else begin
               c.rf_src = 2'd0;
            end
         end
         S_HALT:  c.halted = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t          r_state;
   logic [3:0]      r_op_q;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_fault;
   ctrl_t           r_ctrl;

   state_t          w_next_state;
   logic [3:0]      w_next_op;
   logic [TO_W-1:0] w_next_cnt;
   logic            w_next_fault;

   // Next-state, opcode latch, timeout counter and fault update.
   always_comb begin
      w_next_state = r_state;
      w_next_op    = r_op_q;
      w_next_cnt   = r_to_cnt;
      w_next_fault = r_fault;
      case (r_state)
         S_IDLE: begin
            if (i_run) begin
               w_next_state = S_FETCH;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_FETCH:  w_next_state = S_DECODE;
         S_DECODE: begin
            w_next_op = i_opcode;
            case (i_opcode)
               4'h0, 4'hD, 4'hE: w_next_state = S_FETCH;
               4'hF:             w_next_state = S_HALT;
               default:          w_next_state = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (r_op_q)
               OP_LD, OP_ST: begin
                  w_next_state = S_MEM;
                  w_next_cnt   = '0;
               end
               OP_JMP, OP_JZ: w_next_state = S_FETCH;
               default:       w_next_state = S_WB;
            endcase
         end
         S_MEM: begin
            // A ready on the last allowed cycle still counts as completion.
            if (i_dmem_ready) begin
               if (r_op_q == OP_LD) begin
                  w_next_state = S_WB;
               end else begin
                  w_next_state = S_FETCH;
               end
            end else if (r_to_cnt == TO_LAST) begin
               w_next_state = S_HALT;
               w_next_fault = 1'b1;
            end else begin
               w_next_cnt = r_to_cnt + TO_W'(1);
            end
         end
         S_WB:   w_next_state = S_FETCH;
         S_HALT: w_next_state = S_HALT;
`ifdef CTRL_SINGLE_STEP_EN
         S_STEP_WAIT: begin
            if (i_step) begin
               w_next_state = S_FETCH;
            end else begin
               w_next_state = S_STEP_WAIT;
            end
         end
`endif
         default: w_next_state = S_IDLE;
      endcase
`ifdef CTRL_SINGLE_STEP_EN
      // Every instruction boundary parks in STEP_WAIT until a step pulse.
      if ((w_next_state == S_FETCH) && (r_state != S_STEP_WAIT)) begin
         w_next_state = S_STEP_WAIT;
      end else begin
         w_next_state = w_next_state;
      end
`endif
   end

   // State, datapath-control registers and registered strobes; reset wins.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state  <= S_IDLE;
         r_op_q   <= 4'h0;
         r_to_cnt <= '0;
         r_fault  <= 1'b0;
         r_ctrl   <= '0;
      end else begin
         r_state  <= w_next_state;
         r_op_q   <= w_next_op;
         r_to_cnt <= w_next_cnt;
         r_fault  <= w_next_fault;
         r_ctrl   <= decode_ctrl(w_next_state, w_next_op);
      end
   end

   assign o_pc_load = (r_state == S_EXEC) &&
                      ((r_op_q == OP_JMP) || ((r_op_q == OP_JZ) && i_zero_flag));

   assign o_ir_load = r_ctrl.ir_load;
   assign o_pc_inc  = r_ctrl.pc_inc;
   assign o_alu_en  = r_ctrl.alu_en;
   assign o_alu_op  = r_ctrl.alu_op;
   assign o_rf_we   = r_ctrl.rf_we;
   assign o_rf_src  = r_ctrl.rf_src;
   assign o_dmem_re = r_ctrl.dmem_re;
   assign o_dmem_we = r_ctrl.dmem_we;
   assign o_halted  = r_ctrl.halted;
   assign o_fault   = r_fault;
   assign o_state   = r_state;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm with MEM_TIMEOUT=4; outputs sampled on the
// falling edge and compared against hand-written expected vectors.
module tb_cpu_ctrl_fsm;
   logic       clk;
   logic       reset;
   logic       run;
   logic [3:0] opcode;
   logic       zero;
   logic       ready;
   logic       ir_load, pc_inc, pc_load, alu_en, rf_we, dmem_re, dmem_we, halted, fault;
   logic [2:0] alu_op;
   logic [1:0] rf_src;
   logic [2:0] state;
   int         total;
   int         bad;

   cpu_ctrl_fsm #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
      .i_clock      (clk),
      .i_reset      (reset),
      .i_run        (run),
      .i_opcode     (opcode),
      .i_zero_flag  (zero),
      .i_dmem_ready (ready),
      .o_ir_load    (ir_load),
      .o_pc_inc     (pc_inc),
      .o_pc_load    (pc_load),
      .o_alu_en     (alu_en),
      .o_alu_op     (alu_op),
      .o_rf_we      (rf_we),
      .o_rf_src     (rf_src),
      .o_dmem_re    (dmem_re),
      .o_dmem_we    (dmem_we),
      .o_halted     (halted),
      .o_fault      (fault),
      .o_state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack expected fields: st, ir, pc_inc, pc_load, alu_en, alu_op, rf_we, rf_src, re, we, halted, fault.
   function automatic logic [16:0] mk(input logic [2:0] st, input logic ir, input logic pci,
                                      input logic pcl, input logic alu, input logic [2:0] aop,
                                      input logic we, input logic [1:0] src, input logic re,
                                      input logic wm, input logic h, input logic f);
      return {ir, pci, pcl, alu, aop, we, src, re, wm, h, f, st};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [16:0] exp);
      logic [16:0] obs;
      obs = {ir_load, pc_inc, pc_load, alu_en, alu_op, rf_we, rf_src, dmem_re, dmem_we,
             halted, fault, state};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
      end
   endtask

   localparam logic [16:0] E_IDLE  = 17'h00000;
   localparam logic [16:0] E_FETCH = {1'b1, 1'b1, 12'h000, 3'd1};
   localparam logic [16:0] E_DEC   = {14'h0000, 3'd2};
   localparam logic [16:0] E_EXEC0 = {14'h0000, 3'd3};

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0; run = 1'b1; opcode = 4'h0; zero = 1'b0; ready = 1'b0;
      tick(); tick();
      chk("reset", E_IDLE);
      reset = 1'b1;
      tick(); chk("fetch_first", E_FETCH);
      // ADD
      opcode = 4'h1;
      tick(); chk("add_decode", E_DEC);
      run = 1'b0;
      tick(); chk("add_exec", mk(3'd3,1'b0,1'b0,1'b0,1'b1,3'd0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0));
      tick(); chk("add_wb", mk(3'd5,1'b0,1'b0,1'b0,1'b0,3'd0,1'b1,2'd0,1'b0,1'b0,1'b0,1'b0));
      tick(); chk("add_fetch", E_FETCH);
      // LD with 3 wait cycles; ready lands on the last allowed MEM cycle
      opcode = 4'h8;
      tick(); chk("ld_decode", E_DEC);
      tick(); chk("ld_exec", E_EXEC0);
      for (int i = 0; i < 4; i++) begin
         tick(); chk("ld_mem_re", mk(3'd4,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,1'b1,1'b0,1'b0,1'b0));
         if (i == 3) ready = 1'b1;
      end
      tick(); chk("ld_wb", mk(3'd5,1'b0,1'b0,1'b0,1'b0,3'd0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0));
      ready = 1'b0;
      tick(); chk("ld_fetch", E_FETCH);
      // ST with 1 wait cycle
      opcode = 4'h9;
      tick(); chk("st_decode", E_DEC);
      tick(); chk("st_exec", E_EXEC0);
      tick(); chk("st_mem_wait", mk(3'd4,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0));
      tick(); chk("st_mem_done", mk(3'd4,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0));
      ready = 1'b1;
      tick(); chk("st_fetch", E_FETCH);
      ready = 1'b0;
      // JZ not taken
      opcode = 4'hB;
      tick(); chk("jz0_decode", E_DEC);
      tick(); chk("jz0_exec", E_EXEC0);
      tick(); chk("jz0_fetch", E_FETCH);
      // JZ taken
      tick(); chk("jz1_decode", E_DEC);
      zero = 1'b1;
      tick(); chk("jz1_exec", mk(3'd3,1'b0,1'b0,1'b1,1'b0,3'd0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0));
      tick(); chk("jz1_fetch", E_FETCH);
      zero = 1'b0;
      // NOT
      opcode = 4'h6;
      tick(); chk("not_decode", E_DEC);
      tick(); chk("not_exec", mk(3'd3,1'b0,1'b0,1'b0,1'b1,3'd5,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0));
      tick(); chk("not_wb", mk(3'd5,1'b0,1'b0,1'b0,1'b0,3'd0,1'b1,2'd0,1'b0,1'b0,1'b0,1'b0));
      tick(); chk("not_fetch", E_FETCH);
      // XOR
      opcode = 4'h5;
      tick(); chk("xor_decode", E_DEC);
      tick(); chk("xor_exec", mk(3'd3,1'b0,1'b0,1'b0,1'b1,3'd4,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0));
      tick(); chk("xor_wb", mk(3'd5,1'b0,1'b0,1'b0,1'b0,3'd0,1'b1,2'd0,1'b0,1'b0,1'b0,1'b0));
      tick(); chk("xor_fetch", E_FETCH);
      // LDI
      opcode = 4'hC;
      tick(); chk("ldi_decode", E_DEC);
      tick(); chk("ldi_exec", E_EXEC0);
      tick(); chk("ldi_wb", mk(3'd5,1'b0,1'b0,1'b0,1'b0,3'd0,1'b1,2'd2,1'b0,1'b0,1'b0,1'b0));
      tick(); chk("ldi_fetch", E_FETCH);
      // NOP: two cycles
      opcode = 4'h0;
      tick(); chk("nop_decode", E_DEC);
      tick(); chk("nop_fetch", E_FETCH);
      // ST timeout
      opcode = 4'h9;
      tick(); chk("to_decode", E_DEC);
      tick(); chk("to_exec", E_EXEC0);
      for (int i = 0; i < 4; i++) begin
         tick(); chk("to_mem_we", mk(3'd4,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0));
      end
      tick(); chk("to_halt", mk(3'd6,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,1'b0,1'b0,1'b1,1'b1));
      for (int i = 0; i < 4; i++) begin
         run = ~run;
         tick(); chk("to_halt_hold", mk(3'd6,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,1'b0,1'b0,1'b1,1'b1));
      end
      reset = 1'b0;
      tick(); chk("to_reset", E_IDLE);
      reset = 1'b1; run = 1'b1;
      // Reset in the middle of MEM
      tick(); chk("mid_fetch", E_FETCH);
      opcode = 4'h9;
      tick(); chk("mid_decode", E_DEC);
      tick(); chk("mid_exec", E_EXEC0);
      tick(); chk("mid_mem", mk(3'd4,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0));
      reset = 1'b0;
      tick(); chk("mid_reset", E_IDLE);
      reset = 1'b1;
      // HLT
      tick(); chk("hlt_fetch", E_FETCH);
      opcode = 4'hF;
      tick(); chk("hlt_decode", E_DEC);
      run = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(); chk("hlt_hold", mk(3'd6,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,1'b0,1'b0,1'b1,1'b0));
         run = ~run;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
